// File: rtl/mem_arbiter_n.sv
// rtl/mem_arbiter_n.sv - N-channel cache-to-memory arbiter, fixed or round-robin
// Serves one channel at a time through IDLE -> BUSY -> RELEASE.
module mem_arbiter_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int RR_MODE = 1,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_rw,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]          ch_ack,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic                       grant_valid,
  output logic [ID_W-1:0]            grant_id,
  output logic                       mem_enable,
  output logic                       mem_rw,
  input  logic                       mem_ack,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [DATA_W-1:0]          mem_data_in,
  output logic [DATA_W-1:0]          mem_data_out
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t              state;
  logic [ID_W-1:0]     last;
  logic [ID_W-1:0]     winner;
  logic                any_req;
  logic                sel_rw;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  int                  best_d;
  int                  cur_d;

  always_comb begin
    winner = '0;
    best_d = NUM_CH;
    cur_d  = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      // round-robin ranks each request by its distance past the last served channel
      if (RR_MODE != 0) cur_d = (i - int'(last) - 1 + 2 * NUM_CH) % NUM_CH;
      else              cur_d = i;
      if (ch_req[i] && (cur_d < best_d)) begin
        best_d = cur_d;
        winner = ID_W'(i);
      end
    end
  end

  always_comb begin
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (winner == ID_W'(i)) begin
        sel_rw    = ch_rw[i];
        sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign any_req = |ch_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last         <= ID_W'(NUM_CH - 1);
      ch_ack       <= '0;
      ch_rdata     <= '0;
      grant_valid  <= 1'b0;
      grant_id     <= '0;
      mem_enable   <= 1'b0;
      mem_rw       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          ch_ack <= '0;
          if (any_req) begin
            grant_id     <= winner;
            grant_valid  <= 1'b1;
            mem_enable   <= 1'b1;
            mem_rw       <= sel_rw;
            mem_addr     <= sel_addr;
            mem_data_out <= sel_wdata;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // request lines are ignored here; only the memory completion matters
          if (mem_ack) begin
            ch_ack      <= {{(NUM_CH-1){1'b0}}, 1'b1} << grant_id;
            ch_rdata    <= mem_data_in;
            mem_enable  <= 1'b0;
            grant_valid <= 1'b0;
            mem_rw      <= 1'b0;
            last        <= grant_id;
            state       <= RELEASE;
          end
        end
        RELEASE: begin
          ch_ack     <= '0;
          mem_enable <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
Parametrised N-channel arbiter between the cache miss/writeback ports and the single synchronous memory port. It generalises the fixed three-port (I-cache read, D-cache read, D-cache write) arbiter to NUM_CH channels, each carrying its own read/write flag. It adds a selectable fixed-priority or round-robin policy and exposes the current grant. It sits between the Icache/Dcache instances and the cpu memory ports.

Parameters:
NUM_CH, 3, number of requesting channels (≥2); channel 0 = I-cache read, 1 = D-cache read, 2 = D-cache write by convention
ADDR_W, 32, address width (matches REG_SIZE)
DATA_W, 128, line width (matches WIDTH)
RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
ID_W, 2, width of grant_id; must satisfy 2^ID_W ≥ NUM_CH

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
ch_req  in  NUM_CH  per-channel request, held high until its ch_ack
ch_rw  in  NUM_CH  per-channel direction, 1 = write, 0 = read
ch_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*DATA_W  packed write lines
ch_ack  out  NUM_CH  one-cycle completion pulse, one-hot or zero
ch_rdata  out  DATA_W  read line, valid while any ch_ack bit is high (broadcast)
grant_valid  out  1  a transaction is in flight
grant_id  out  ID_W  channel currently being served
mem_enable  out  1  memory request
mem_rw  out  1  1 = write
mem_ack  in  1  memory completion
mem_addr  out  ADDR_W  memory address
mem_data_in  in  DATA_W  data returned from memory
mem_data_out  out  DATA_W  data written to memory

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- All outputs are registered. On reset every output is 0, the FSM goes to IDLE, and the round-robin pointer last = NUM_CH-1, so channel 0 has top priority first.
- FSM states: IDLE, BUSY, RELEASE.
- IDLE: if any ch_req bit is high, choose a winner w.
  - Fixed mode: lowest index wins.
  - RR mode: search from last+1 upward, wrapping modulo NUM_CH.
  - On the edge: latch grant_id=w, grant_valid=1, mem_addr, mem_rw and mem_data_out from channel w; set mem_enable=1; go to BUSY.
  - If no request, stay in IDLE with outputs unchanged except ch_ack=0.
- BUSY: mem_enable stays 1 and the latched fields stay stable. ch_req/ch_addr changes on any channel are ignored, including the served channel dropping its request; the transaction still completes.
  - On an edge with mem_ack=1: ch_ack[grant_id] is set for exactly one cycle; ch_rdata takes mem_data_in (reads; writes also copy it, but the value is don't-care); mem_enable, grant_valid and mem_rw clear; last=grant_id; go to RELEASE.
- RELEASE: one cycle. mem_enable=0, ch_ack returns to 0, and all requests are ignored. This gives the served requester one cycle to drop ch_req and the memory one cycle to see enable low. Next state is IDLE.
- mem_ack is sampled only in BUSY; a stale or held mem_ack in IDLE or RELEASE has no effect.
- Latency:
  - Request first sampled at edge t → mem_enable high after t.
  - mem_ack sampled at edge u → ch_ack high for the cycle after u.
  - Minimum gap between two back-to-back grants: 2 cycles after ack (RELEASE, then IDLE decision).
- Simultaneous events:
  - A new request arriving in the same cycle a grant is decided waits for the next IDLE.
  - A request for the just-served channel in IDLE competes normally. In RR mode it has the lowest priority.
- Reset mid-transaction: the transaction is abandoned, mem_enable drops on the reset edge, no ch_ack is produced, and the RR pointer is reinitialised.
- A channel deasserting ch_req while not granted is legal and loses nothing.
- Direction per channel comes from ch_rw, not from channel index.

Test Plan:
- Reset: assert reset with ch_req=3'b111 → all outputs 0 through reset. The first grant after release is channel 0, in both modes.
- Single read: ch_req[1]=1, ch_rw[1]=0, addr 0x100; memory acks after 3 BUSY cycles with 0xDEAD…BEEF → mem_enable high 4 cycles, ch_ack=3'b010 for one cycle with ch_rdata=0xDEAD…BEEF; next cycle mem_enable=0.
- Fixed priority (RR_MODE=0): ch_req=3'b110 held after each ack → ch 1 is always granted and ch 2 is starved. Then drop ch 1 → ch 2 granted, mem_rw=1, mem_data_out equals ch_wdata slice 2.
- Round-robin (RR_MODE=1): all three channels request continuously → grant order 0,1,2,0,1,2, each grant separated by RELEASE and IDLE cycles.
- Glitching inputs: in BUSY, change ch_addr[granted] and drop its ch_req, and hold mem_ack high into RELEASE → mem_addr unchanged, a single ch_ack pulse, no second grant from the stale mem_ack.
- Reset mid-BUSY: assert reset for one edge while BUSY → mem_enable=0 the next cycle, no ch_ack, FSM in IDLE.
- NUM_CH=5 build: requests on channels 4 and 0 in RR mode → channel 0 first, then 4.
